// File: rtl/rf_scoreboard.sv
// rf_scoreboard: parametrised register file with a per-register pending-write
// scoreboard for the pipelined datapath.
//   - NRD independent combinational read ports, one writeback port.
//   - Register 0 reads as zero and is never pending.
//   - Issue (IsEn/Rd) marks a destination pending; writeback (WrEn/Rw) clears it.
//   - PendCnt tracks the number of pending registers incrementally.
// Build option: define RF_BYPASS_EN to forward same-cycle writeback data
// (and readiness) to the read ports.  The default build has no forwarding.
module rf_scoreboard #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 WrEn,
    input  logic [AW-1:0]        Rw,
    input  logic [WIDTH-1:0]     busW,
    input  logic                 IsEn,
    input  logic [AW-1:0]        Rd,
    input  logic [NRD*AW-1:0]    Ra,
    output logic [NRD*WIDTH-1:0] busR,
    output logic [NRD-1:0]       Rdy,
    output logic [AW:0]          PendCnt
);

    localparam int NREG = 1 << AW;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]  pend_q;
    logic [NREG-1:0]  pend_d;
    logic [AW:0]      pend_cnt_q;
    logic [AW:0]      pend_cnt_d;

    logic             wr_ok;
    logic             is_ok;
    logic             set_new;
    logic             clr_new;
    logic [AW-1:0]    ra_sel [NRD];

    // Writes and issues addressed to register 0 have no effect.
    assign wr_ok = WrEn && (Rw != '0);
    assign is_ok = IsEn && (Rd != '0);

    // A clear only counts when the same cycle's issue does not re-mark that
    // register; the new producer wins and the bit stays set.
    assign set_new = is_ok && !pend_q[Rd];
    assign clr_new = wr_ok && pend_q[Rw] && !(is_ok && (Rd == Rw));

    // Next-state for register contents, pending bits and pending count.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_ok) begin
            regs_d[Rw] = busW;
            pend_d[Rw] = 1'b0;
        end
        if (is_ok) begin
            pend_d[Rd] = 1'b1;
        end
        pend_cnt_d = pend_cnt_q
                   + {{AW{1'b0}}, set_new}
                   - {{AW{1'b0}}, clr_new};
    end

    // State registers with synchronous active-low reset overriding all updates.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            regs_q     <= '{default: '0};
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Combinational read ports with readiness derived from the scoreboard.
    always_comb begin
        busR = '0;
        Rdy  = '0;
        for (int k = 0; k < NRD; k++) begin
            ra_sel[k] = Ra[k*AW +: AW];
            busR[k*WIDTH +: WIDTH] = regs_q[ra_sel[k]];
            Rdy[k] = !pend_q[ra_sel[k]];
`ifdef RF_BYPASS_EN
            if (wr_ok && (ra_sel[k] == Rw)) begin
                busR[k*WIDTH +: WIDTH] = busW;
                Rdy[k] = 1'b1;
            end
`endif
            if (ra_sel[k] == '0) begin
                busR[k*WIDTH +: WIDTH] = '0;
                Rdy[k] = 1'b1;
            end
        end
    end

    assign PendCnt = pend_cnt_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard (default parameters). Directed vector table,
// hand-written saturation / reset sequence, then random traffic against a
// behavioural model that keeps register values and a pending set as arrays.
module tb_rf_scoreboard;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk;
    logic        Rst_n;
    logic        WrEn;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic        IsEn;
    logic [4:0]  Rd;
    logic [9:0]  Ra;
    logic [63:0] busR;
    logic [1:0]  Rdy;
    logic [5:0]  PendCnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mdl_r [32];
    bit          mdl_p [32];

    rf_scoreboard #(.WIDTH(32), .AW(5), .NRD(2)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .WrEn    (WrEn),
        .Rw      (Rw),
        .busW    (busW),
        .IsEn    (IsEn),
        .Rd      (Rd),
        .Ra      (Ra),
        .busR    (busR),
        .Rdy     (Rdy),
        .PendCnt (PendCnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic        is;
        logic [4:0]  rd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] eb0;
        logic [31:0] eb1;
        logic [1:0]  erdy;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic rst_n, input logic we, input logic [4:0] rw,
                         input logic [31:0] bw, input logic is, input logic [4:0] rd,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        Rst_n = rst_n;
        WrEn  = we;
        Rw    = rw;
        busW  = bw;
        IsEn  = is;
        Rd    = rd;
        Ra    = {ra1, ra0};
    endtask

    // Model update from the rules, then advance one clock; outputs sampled 1ns later.
    task automatic tick();
        if (!Rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mdl_r[i] = '0;
                mdl_p[i] = 1'b0;
            end
        end else begin
            if (WrEn && Rw != 0) begin
                mdl_r[Rw] = busW;
                mdl_p[Rw] = 1'b0;
            end
            if (IsEn && Rd != 0) mdl_p[Rd] = 1'b1;
        end
        @(posedge Clk);
        #1;
    endtask

    function automatic logic fwd(input logic [4:0] a);
        return BYP && WrEn && (Rw != 0) && (a == Rw);
    endfunction

    function automatic logic [31:0] m_bus(input logic [4:0] a);
        if (a == 0) return '0;
        if (fwd(a)) return busW;
        return mdl_r[a];
    endfunction

    function automatic logic m_rdy(input logic [4:0] a);
        if (a == 0) return 1'b1;
        if (fwd(a)) return 1'b1;
        return !mdl_p[a];
    endfunction

    function automatic logic [5:0] m_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) if (mdl_p[i]) c++;
        return 6'(c);
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, " bus0"}, {32'h0, busR[31:0]},  {32'h0, m_bus(Ra[4:0])});
        chk({tag, " bus1"}, {32'h0, busR[63:32]}, {32'h0, m_bus(Ra[9:5])});
        chk({tag, " rdy"},  {62'h0, Rdy},         {62'h0, m_rdy(Ra[9:5]), m_rdy(Ra[4:0])});
        chk({tag, " cnt"},  {58'h0, PendCnt},     {58'h0, m_cnt()});
    endtask

    initial begin
        vecs[0]  = '{1,0,0,0,0,0,5,0,   0, 0, 2'b11, 0};
        vecs[1]  = '{1,1,5,32'h1234,0,0,5,0,   BYP ? 32'h1234 : 32'h0, 0, 2'b11, 0};
        vecs[2]  = '{0,0,0,0,0,0,5,0,   32'h1234, 0, 2'b11, 0};
        vecs[3]  = '{1,0,0,0,0,0,5,0,   0, 0, 2'b11, 0};
        vecs[4]  = '{1,1,18,32'hA,0,0,18,0,   BYP ? 32'hA : 32'h0, 0, 2'b11, 0};
        vecs[5]  = '{1,1,0,32'hFFFF_FFFF,0,0,18,0,   32'hA, 0, 2'b11, 0};
        vecs[6]  = '{1,0,0,0,0,0,18,0,   32'hA, 0, 2'b11, 0};
        vecs[7]  = '{1,1,20,32'h3000,0,0,20,18,   BYP ? 32'h3000 : 32'h0, 32'hA, 2'b11, 0};
        vecs[8]  = '{1,0,0,0,0,0,20,0,   32'h3000, 0, 2'b11, 0};
        vecs[9]  = '{1,0,0,0,1,7,7,0,   0, 0, 2'b11, 0};
        vecs[10] = '{1,0,0,0,0,0,7,0,   0, 0, 2'b10, 1};
        vecs[11] = '{1,1,7,32'h55,0,0,7,7,   BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0,
                     BYP ? 2'b11 : 2'b00, 1};
        vecs[12] = '{1,0,0,0,0,0,7,0,   32'h55, 0, 2'b11, 0};
        vecs[13] = '{1,0,0,0,1,9,9,0,   0, 0, 2'b11, 0};
        vecs[14] = '{1,1,9,32'h99,1,9,9,0,   BYP ? 32'h99 : 32'h0, 0, BYP ? 2'b11 : 2'b10, 1};
        vecs[15] = '{1,1,9,32'h77,1,3,9,3,   BYP ? 32'h77 : 32'h99, 0, BYP ? 2'b11 : 2'b10, 1};
        vecs[16] = '{1,0,0,0,0,0,9,3,   32'h77, 0, 2'b01, 1};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst_n, vecs[i].we, vecs[i].rw, vecs[i].busw,
                  vecs[i].is, vecs[i].rd, vecs[i].ra0, vecs[i].ra1);
            #1;
            chk($sformatf("vec%0d bus0", i), {32'h0, busR[31:0]},  {32'h0, vecs[i].eb0});
            chk($sformatf("vec%0d bus1", i), {32'h0, busR[63:32]}, {32'h0, vecs[i].eb1});
            chk($sformatf("vec%0d rdy", i),  {62'h0, Rdy},         {62'h0, vecs[i].erdy});
            chk($sformatf("vec%0d cnt", i),  {58'h0, PendCnt},     {58'h0, vecs[i].ecnt});
            tick();
        end

        // Fill the scoreboard: every non-zero register pending.
        for (int r = 1; r < 32; r++) begin
            drive(1, 0, 0, 0, 1, 5'(r), 0, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 4, 31);
        #1;
        chk("sat cnt", {58'h0, PendCnt}, 64'd31);
        chk("sat rdy", {62'h0, Rdy}, 64'd0);
        drive(1, 0, 0, 0, 1, 4, 4, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 4, 0);
        #1;
        chk("reissue cnt", {58'h0, PendCnt}, 64'd31);
        chk("reissue rdy", {62'h0, Rdy}, 64'b10);

        // Reset wins over a same-cycle write and issue.
        drive(0, 1, 5, 32'hDEAD_BEEF, 1, 6, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 5, 6);
        #1;
        chk("rst cnt",  {58'h0, PendCnt}, 64'd0);
        chk("rst rdy",  {62'h0, Rdy}, 64'b11);
        chk("rst bus",  busR, 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] rw, rd, a0, a1;
            rw = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a0 = ($urandom_range(0, 1) == 0) ? rw : 5'($urandom_range(0, 9));
            a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
            drive(($urandom_range(0, 49) != 0), 1'($urandom), rw, $urandom,
                  1'($urandom), rd, a0, a1);
            #1;
            chk_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
